utmi_tx_packetizer: RTL
=======================

Name: utmi_tx_packetizer

Overview:
- Parametrised UTMI transmit packet engine between the link layer and the line-side bit serializer.
- Accepts a packet command (PID plus an empty/non-empty flag) and a byte stream with valid/ready/last.
- Buffers the payload in a small holding FIFO and emits SYNC, PID, payload, optional CRC16 and an EOP marker, one byte per serializer handshake.
- Adds a bounded data-wait, underrun abort and back-to-back packets, none of which the previous TX state machine supports.

Parameters:
- HOLD_DEPTH, 4: payload holding FIFO depth in bytes; power of two, at least 2.
- SYNC_BYTE, 8'h80: byte emitted in the SYNC slot.
- MAX_WAIT, 16: cycles the engine tolerates an empty FIFO mid-payload before aborting; at least 1.
- CRC_EN, 1: when 1, CRC16 is appended to DATA PIDs; when 0, never appended.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  packet command present
- cmd_ready  out  1  engine accepts the command (IDLE only)
- cmd_pid  in  4  PID value
- cmd_empty  in  1  packet has no payload
- in_data  in  8  payload byte
- in_valid  in  1  payload byte valid
- in_last  in  1  final payload byte
- in_ready  out  1  FIFO not full
- ser_data  out  8  byte to serializer
- ser_valid  out  1  ser_data valid
- ser_eop  out  1  current byte slot is the EOP marker (ser_data = 8'h00)
- ser_abort  out  1  qualifies the EOP as an abort (bit-stuff-error EOP)
- ser_ready  in  1  serializer consumed the byte
- busy  out  1  state is not IDLE
- underrun  out  1  one-cycle pulse when a packet is aborted

Behaviour:
- Reset: state IDLE, FIFO emptied, CRC register 16'hFFFF, all outputs 0 except cmd_ready=1 and in_ready=1. Reset mid-packet drops the packet with no EOP.
- Output handshake: ser_data, ser_eop and ser_abort are registered and held stable while ser_valid=1 and ser_ready=0. A byte advances only on ser_valid & ser_ready.
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP.
- IDLE: cmd_valid & cmd_ready latches the PID and empty flag, then moves to SYNC. ser_valid rises on the next cycle.
- SYNC: drives SYNC_BYTE. On handshake, goes to PID.
- PID: drives {~pid, pid}. On handshake:
  - goes to DATA if not empty;
  - else goes to CRC_LO if it is a DATA PID;
  - else goes to EOP.
- DATA PID test: pid[1:0]==2'b11 and CRC_EN=1.
- DATA:
  - Drives the FIFO head byte. The byte is popped on handshake and fed to the CRC.
  - After the byte tagged last is sent, goes to CRC_LO for a DATA PID, otherwise to EOP.
- CRC16: reflected polynomial 16'hA001, init 16'hFFFF, processed LSB-first per byte. CRC_LO sends ~crc[7:0], then CRC_HI sends ~crc[15:8], then EOP.
- EOP: drives ser_eop=1, ser_data=8'h00. On handshake, goes to IDLE and reinitialises the CRC.
- Back-to-back: a command presented in the same cycle the engine re-enters IDLE is accepted the following cycle. The minimum gap is one cycle with ser_valid=0.
- FIFO:
  - in_ready = !full. A push and a pop in the same cycle are both allowed when full.
  - Bytes may be prefilled while the engine is in IDLE/SYNC/PID.
  - Bytes pushed after an accepted last byte belong to the next packet.
- Data wait:
  - In DATA with the FIFO empty, ser_valid=0 and a wait counter increments each cycle.
  - The counter resets on every pop.
  - When the counter reaches MAX_WAIT: pulse underrun, go to EOP with ser_abort=1, skip CRC, and flush nothing.
  - The late bytes of the aborted packet are discarded until its in_last has been accepted.
- A DATA packet with an empty payload sends CRC bytes 8'h00, 8'h00.

Decomposition:
- Shared package utmi_pkg:
  - state enum;
  - PID constants (OUT 4'h1, IN 4'h9, SOF 4'h5, SETUP 4'hD, DATA0 4'h3, DATA1 4'hB, ACK 4'h2, NAK 4'hA, STALL 4'hE);
  - CRC16 poly/init constants;
  - a crc16_byte function.
- Sub-module: utmi_hold_fifo, parametrised by HOLD_DEPTH, 9 bits wide (data plus last).

Test Plan:
- ACK handshake: cmd_pid=4'h2, cmd_empty=1, ser_ready tied 1 -> ser_data sequence 8'h80, 8'hD2, then EOP (ser_eop=1, data 8'h00); busy returns low.
- Zero-length DATA0: cmd_pid=4'h3, cmd_empty=1 -> 8'h80, 8'hC3, 8'h00, 8'h00, EOP; no payload popped.
- OUT token: pid 4'h1, payload 8'h15, 8'h00 (last) -> 8'h80, 8'hE1, 8'h15, 8'h00, EOP; no CRC bytes emitted.
- Backpressure: DATA1 with 3 bytes 8'hA5, 8'h5A, 8'hFF, ser_ready toggling every other cycle -> ser_data stable while stalled, no byte lost or duplicated; CRC matches the package function.
- Underrun: DATA0, 1 byte pushed with no last, MAX_WAIT=16 -> after 16 empty cycles underrun pulses once, EOP emitted with ser_abort=1, and later bytes up to in_last are discarded.
- Reset mid-DATA plus back-to-back: assert reset during DATA -> all outputs at reset values next cycle. Then two queued ACK commands -> second SYNC starts exactly one idle cycle after the first EOP handshake.

Source files
------------

// File: rtl/utmi_tx_packetizer_pkg.sv
// Shared types, PID/CRC constants and the CRC16 byte step for the UTMI TX engine.
package utmi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_EOP
  } tx_state_e;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One serializer byte slot: what is on the wire plus the payload last tag.
  typedef struct packed {
    logic [7:0] data;
    logic       eop;
    logic       abort;
    logic       last;
  } slot_t;

  function automatic slot_t mk_slot(input logic [7:0] data, input logic eop,
                                    input logic abort, input logic last);
    slot_t s;
    s.data  = data;
    s.eop   = eop;
    s.abort = abort;
    s.last  = last;
    return s;
  endfunction

  function automatic logic is_data_pid(input logic [3:0] pid);
    return pid[1:0] == 2'b11;
  endfunction

  // Reflected CRC16 step, data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/utmi_tx_packetizer_if.sv
// Link-side command/payload handshakes and serializer-side byte handshake.
interface utmi_tx_packetizer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_pid;
  logic       cmd_empty;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] ser_data;
  logic       ser_valid;
  logic       ser_eop;
  logic       ser_abort;
  logic       ser_ready;

  modport master (
    output cmd_valid, cmd_pid, cmd_empty, in_data, in_valid, in_last, ser_ready,
    input  cmd_ready, in_ready, ser_data, ser_valid, ser_eop, ser_abort
  );

  modport slave (
    input  cmd_valid, cmd_pid, cmd_empty, in_data, in_valid, in_last, ser_ready,
    output cmd_ready, in_ready, ser_data, ser_valid, ser_eop, ser_abort
  );
endinterface

// File: rtl/utmi_tx_packetizer_hold_fifo.sv
// Payload holding FIFO; push while full is accepted only alongside a pop.
module utmi_hold_fifo #(
  parameter int unsigned HOLD_DEPTH = 4,
  parameter int unsigned WIDTH      = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned AW = $clog2(HOLD_DEPTH);

  logic [WIDTH-1:0] mem_q [HOLD_DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/utmi_tx_packetizer.sv
// UTMI TX packet engine: SYNC, PID, buffered payload, optional CRC16, EOP,
// with bounded data wait, underrun abort and back-to-back packets.
module utmi_tx_packetizer
  import utmi_pkg::*;
#(
  parameter int unsigned HOLD_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'h80,
  parameter int unsigned MAX_WAIT   = 16,
  parameter bit          CRC_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  utmi_tx_packetizer_if.slave   bus,
  output logic                  busy,
  output logic                  underrun
);
  localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  tx_state_e   state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic        empty_q, empty_d;
  logic [15:0] crc_q, crc_d;
  logic [WW-1:0] wait_q, wait_d;
  logic        drop_q, drop_d;
  slot_t       slot_q, slot_d;
  logic        valid_q, valid_d;
  logic        underrun_q, underrun_d;

  logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [8:0]  fifo_dout;
  logic        hs, data_pkt, abort_now;
  slot_t       head_slot;

  assign hs        = valid_q && bus.ser_ready;
  assign data_pkt  = CRC_EN && is_data_pid(pid_q);
  assign head_slot = mk_slot(fifo_dout[7:0], 1'b0, 1'b0, fifo_dout[8]);
  assign fifo_push = bus.in_valid && !drop_q && !abort_now;

  utmi_hold_fifo #(.HOLD_DEPTH(HOLD_DEPTH), .WIDTH(9)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .din_i   ({bus.in_last, bus.in_data}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    empty_d    = empty_q;
    crc_d      = crc_q;
    wait_d     = wait_q;
    drop_d     = drop_q;
    slot_d     = slot_q;
    valid_d    = valid_q;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    abort_now  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          pid_d   = bus.cmd_pid;
          empty_d = bus.cmd_empty;
          state_d = S_SYNC;
          slot_d  = mk_slot(SYNC_BYTE, 1'b0, 1'b0, 1'b0);
          valid_d = 1'b1;
        end
      end
      S_SYNC: begin
        if (hs) begin
          state_d = S_PID;
          slot_d  = mk_slot({~pid_q, pid_q}, 1'b0, 1'b0, 1'b0);
        end
      end
      S_PID: begin
        if (hs) begin
          if (!empty_q) begin
            state_d = S_DATA;
            wait_d  = '0;
            valid_d = !fifo_empty;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              slot_d   = head_slot;
            end
          end else if (data_pkt) begin
            state_d = S_CRC_LO;
            slot_d  = mk_slot(~crc_q[7:0], 1'b0, 1'b0, 1'b0);
          end else begin
            state_d = S_EOP;
            slot_d  = mk_slot(8'h00, 1'b1, 1'b0, 1'b0);
          end
        end
      end
      S_DATA: begin
        // The output slot doubles as the FIFO head: a byte is popped when it
        // moves into the slot and enters the CRC when the serializer takes it.
        if (hs) begin
          crc_d  = crc16_byte(crc_q, slot_q.data);
          wait_d = '0;
          if (slot_q.last) begin
            if (data_pkt) begin
              state_d = S_CRC_LO;
              slot_d  = mk_slot(~crc_d[7:0], 1'b0, 1'b0, 1'b0);
            end else begin
              state_d = S_EOP;
              slot_d  = mk_slot(8'h00, 1'b1, 1'b0, 1'b0);
            end
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            slot_d   = head_slot;
          end else begin
            valid_d = 1'b0;
          end
        end else if (!valid_q) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            slot_d   = head_slot;
            valid_d  = 1'b1;
            wait_d   = '0;
          end else if (wait_q == WAIT_LAST) begin
            abort_now  = 1'b1;
            underrun_d = 1'b1;
            state_d    = S_EOP;
            slot_d     = mk_slot(8'h00, 1'b1, 1'b1, 1'b0);
            valid_d    = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      S_CRC_LO: begin
        if (hs) begin
          state_d = S_CRC_HI;
          slot_d  = mk_slot(~crc_q[15:8], 1'b0, 1'b0, 1'b0);
        end
      end
      S_CRC_HI: begin
        if (hs) begin
          state_d = S_EOP;
          slot_d  = mk_slot(8'h00, 1'b1, 1'b0, 1'b0);
        end
      end
      S_EOP: begin
        if (hs) begin
          state_d = S_IDLE;
          slot_d  = '0;
          valid_d = 1'b0;
          crc_d   = CRC16_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Late bytes of an aborted packet are swallowed up to and including its last.
    if (abort_now)                                  drop_d = !(bus.in_valid && bus.in_last);
    else if (drop_q && bus.in_valid && bus.in_last) drop_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pid_q      <= '0;
      empty_q    <= 1'b0;
      crc_q      <= CRC16_INIT;
      wait_q     <= '0;
      drop_q     <= 1'b0;
      slot_q     <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      empty_q    <= empty_d;
      crc_q      <= crc_d;
      wait_q     <= wait_d;
      drop_q     <= drop_d;
      slot_q     <= slot_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.in_ready  = !fifo_full;
  assign bus.ser_data  = slot_q.data;
  assign bus.ser_valid = valid_q;
  assign bus.ser_eop   = slot_q.eop;
  assign bus.ser_abort = slot_q.abort;
  assign busy          = (state_q != S_IDLE);
  assign underrun      = underrun_q;
endmodule
